// File: rtl/pkt_framer.sv
// Frames payload words into {header, payload, sequence} packets behind a valid/ready handshake.
// Optional header/sequence error injection is enabled by defining PKT_FRAMER_ERR_INJECT_EN.
module pkt_framer #(
    parameter int unsigned BUS_SIZE  = 16,
    parameter int unsigned WORD_SIZE = 4,
    parameter int unsigned WORD_NUM  = BUS_SIZE / WORD_SIZE,
    parameter int unsigned PAY_SIZE  = BUS_SIZE - 2 * WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 resync,
    input  logic [PAY_SIZE-1:0]  pay_in,
    input  logic                 pay_valid,
    output logic                 pay_ready,
    output logic [BUS_SIZE-1:0]  data_out,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef PKT_FRAMER_ERR_INJECT_EN
    input  logic                 inj_hdr,
    input  logic                 inj_seq,
`endif
    output logic [WORD_SIZE-1:0] seq_count,
    output logic [1:0]           state
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StActive = 2'd1,
        StDrain  = 2'd2
    } state_e;

    localparam int unsigned         HdrLsb  = (WORD_NUM - 1) * WORD_SIZE;
    localparam logic [WORD_SIZE-1:0] HdrOnes = '1;
    localparam logic [WORD_SIZE-1:0] HdrErr  = {{(WORD_SIZE - 1){1'b1}}, 1'b0};
    localparam logic [WORD_SIZE-1:0] SeqOne  = {{(WORD_SIZE - 1){1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic [BUS_SIZE-1:0]   data_q, data_d;
    logic                  valid_q, valid_d;
    logic [WORD_SIZE-1:0]  seq_q, seq_d;

    logic                  load;
    logic [WORD_SIZE-1:0]  hdr_field;
    logic [WORD_SIZE-1:0]  seq_field;

    always_comb begin
        hdr_field = HdrOnes;
        seq_field = seq_q;
`ifdef PKT_FRAMER_ERR_INJECT_EN
        if (inj_hdr) begin
            hdr_field = HdrErr;
        end
        if (inj_seq) begin
            seq_field = seq_q + SeqOne;
        end
`endif
    end

    assign pay_ready = (state_q == StActive) && enable && (!valid_q || out_ready);
    assign load      = pay_valid && pay_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StActive;
                end
            end
            StActive: begin
                if (!enable) begin
                    state_d = (valid_q && !out_ready) ? StDrain : StIdle;
                end
            end
            StDrain: begin
                // Always passes through IDLE, even if enable has come back.
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        seq_d   = seq_q;
        if (load) begin
            data_d                      = '0;
            data_d[HdrLsb +: WORD_SIZE] = hdr_field;
            data_d[WORD_SIZE +: PAY_SIZE] = pay_in;
            data_d[0 +: WORD_SIZE]      = seq_field;
            valid_d                     = 1'b1;
            seq_d                       = seq_q + SeqOne;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
        // resync wins over the increment; the loaded packet keeps the old number.
        if (resync) begin
            seq_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            data_q  <= '0;
            valid_q <= 1'b0;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            seq_q   <= seq_d;
        end
    end

    assign data_out  = data_q;
    assign out_valid = valid_q;
    assign seq_count = seq_q;
    assign state     = state_q;

endmodule

// File: doc/pkt_framer.md
Name: pkt_framer

Overview:
- Upstream source stage for the packet state checker.
- Takes raw payload words over a valid/ready handshake and frames each into one BUS_SIZE-bit packet.
- Frame layout: all-ones header word in the top WORD_SIZE bits, payload in the middle, running sequence number in the low WORD_SIZE bits.
- Its output drives the checker's data_in directly, so in normal operation the checker never leaves FIRSTPKT/REGPKT.

Parameters:
- BUS_SIZE, 16, width of the framed packet.
- WORD_SIZE, 4, width of the header field and the sequence field.
- WORD_NUM, BUS_SIZE/WORD_SIZE, word count per packet; must be >= 3.
- PAY_SIZE, BUS_SIZE-2*WORD_SIZE, payload width (default 8).

Ports:
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  asynchronous, active-low reset; this is already decided.
- enable  input  1  level, 1 = framer may accept payloads.
- resync  input  1  single-cycle pulse; restarts the sequence at 0.
- pay_in  input  PAY_SIZE  payload word.
- pay_valid  input  1  pay_in is valid.
- pay_ready  output  1  framer accepts pay_in this cycle.
- data_out  output  BUS_SIZE  framed packet; feeds the checker's data_in.
- out_valid  output  1  data_out holds a packet.
- out_ready  input  1  downstream consumes data_out this cycle.
- seq_count  output  WORD_SIZE  sequence number for the next packet to be framed.
- state  output  2  current FSM state, for debug.

Behaviour:
- Reset (reset=0, async, dominates everything):
  - state=IDLE, data_out=0, out_valid=0, seq_count=0, pay_ready=0.
  - Asserting reset mid-transfer drops the pending packet without any handshake.
- FSM states: IDLE=0, ACTIVE=1, DRAIN=2.
  - IDLE -> ACTIVE when enable=1.
  - ACTIVE -> DRAIN when enable=0 and out_valid=1 and out_ready=0.
  - ACTIVE -> IDLE when enable=0 and the output register is empty or being consumed this cycle.
  - DRAIN -> IDLE on out_ready=1. A DRAIN that sees enable=1 again still finishes in IDLE first.
- pay_ready = (state==ACTIVE) and enable and (!out_valid or out_ready). It is combinational and never depends on pay_valid.
- Load: on pay_valid and pay_ready, at the next edge:
  - data_out = {all-ones WORD_SIZE, pay_in, seq_count}.
  - out_valid = 1.
  - seq_count increments by 1.
  - Latency is 1 cycle from payload acceptance to out_valid.
  - Back-to-back loads give full throughput with out_ready held at 1.
- Sequence counter:
  - WORD_SIZE bits, modulo 2^WORD_SIZE; 0xF wraps to 0x0 with no flag.
  - Changes only on a load or on resync.
- Output hold: while out_valid=1 and out_ready=0, data_out and out_valid are held stable.
- Output clear: if out_ready=1 with no new load, out_valid goes to 0 next cycle and data_out keeps its last value.
- resync:
  - Sets seq_count=0 at the next edge.
  - If a load happens in the same cycle, the loaded packet still uses the pre-resync seq_count, and seq_count ends at 0, not +1.
  - Has no effect on the packet already in data_out.
- In IDLE, pay_valid is ignored and nothing is loaded.

Optional Feature:
- Macro: PKT_FRAMER_ERR_INJECT_EN.
- Defined:
  - Adds inputs inj_hdr and inj_seq (1 bit each), sampled on a load.
  - inj_hdr=1 replaces the header field with all-ones minus 1 (0xE for WORD_SIZE=4), which drives the checker to F_ERR.
  - inj_seq=1 places seq_count+1 in the sequence field, which drives the checker to SEQ_ERR. The internal seq_count still advances by only 1.
  - Both set: both corruptions applied.
- Undefined: the ports do not exist and framing is always correct.

Test Plan:
- Reset check: reset=0 with random inputs -> data_out=0x0000, out_valid=0, pay_ready=0, seq_count=0. Release reset, enable=1 -> state=ACTIVE next cycle, pay_ready=1.
- Streaming: enable=1, out_ready=1, pay_in=0xAB then 0xCD on consecutive cycles -> data_out=0xFAB0 then 0xFCD1 on consecutive cycles; seq_count=2.
- Backpressure: out_ready=0 after the first load of 0x12 -> data_out holds 0xF120; pay_ready=0 until out_ready=1; the next payload 0x34 appears as 0xF341.
- Wrap: 17 consecutive loads of 0x00 -> the 16th packet is 0xF00F, the 17th is 0xF000, seq_count=1.
- Resync and drain:
  - resync pulse together with a load at seq_count=5 -> packet field=5, seq_count=0 after.
  - enable=0 while stalled -> state=DRAIN, then IDLE on the cycle after out_ready=1.
  - Async reset asserted mid-stream -> out_valid=0 immediately, without waiting for a clock edge.
- With PKT_FRAMER_ERR_INJECT_EN defined:
  - inj_hdr=1 on a load of 0x55 at seq 3 -> packet 0xE553.
  - inj_seq=1 on the next load of 0x55 -> packet 0xF555; seq_count=5 afterwards.
